fp_mul_pipe: RTL
================

// Module: fp_mul_pipe
// PURPOSE
//  Parametrised, pipelined IEEE-754-style floating-point multiplier; successor to the combinational
//  half-precision multiplier. Generic exponent/mantissa widths, valid/ready streaming, full special-value
//  handling and exception flags. Sits in the datapath between operand source and result sink.
// PARAMETERS
//  EXP_W   5    exponent field width (5=half, 8=single)
//  MAN_W   10   stored mantissa width, hidden bit excluded (10=half, 23=single)
//  (derived) W = 1+EXP_W+MAN_W, BIAS = 2**(EXP_W-1)-1
// PORTS
//  clk        in   1    clock, rising edge
//  rst_n      in   1    asynchronous active-low reset
//  in_valid   in   1    operand pair valid
//  in_ready   out  1    block accepts operands this cycle
//  a          in   W    operand A {sign,exp,man}
//  b          in   W    operand B
//  out_valid  out  1    result valid
//  out_ready  in   1    sink accepts result
//  result     out  W    product
//  flags      out  4    {nv,of,uf,nx}: invalid, overflow, underflow, inexact
// BEHAVIOUR
//  - Reset: out_valid=0, result=0, flags=0, all stage valids cleared; in_ready=1 from the first cycle after reset release.
//  - Pipeline of 3 stages: S1 unpack/classify, sign xor, exponent sum (EXP_W+2 bits signed) minus BIAS;
//    S2 (MAN_W+1)x(MAN_W+1) product; S3 normalise (shift 1 if product bit 2*MAN_W+1 set, exp+1), round, pack.
//  - Latency: exactly 3 cycles from accept (in_valid&&in_ready) to out_valid with no stall.
//  - Stall: adv = !out_valid || out_ready; in_ready = adv; all stages shift only when adv=1 (global enable).
//    Accepted operands are never dropped or duplicated; result/flags are held stable while out_valid&&!out_ready.
//  - Throughput 1/cycle when out_ready held high; in_valid=0 inserts bubbles (stage valid=0).
//  - Subnormal inputs (exp=0) are treated as signed zero (flush-to-zero); subnormal results are never produced.
//  - Specials (priority order): any NaN, or inf*0 -> canonical qNaN {0,all-ones,1000..0}, nv=1;
//    inf*finite -> signed inf; zero*finite -> signed zero; all specials nx=0 except as stated.
//  - Overflow: biased result exp >= 2**EXP_W-1 after normalise/round -> signed inf, of=1, nx=1.
//  - Underflow: biased result exp <= 0 -> signed zero, uf=1, nx=1.
//  - nx=1 whenever any discarded product bit is nonzero.
//  - Mantissa-round carry-out (1.11..1 -> 10.0) renormalises: mantissa=0, exp+1, then overflow check.
//  - Reset mid-operation: all in-flight operations are discarded, no output produced for them.
// CONFIGURATION
//  FP_MUL_ROUND_RNE_EN defined: round-to-nearest-even using guard/round/sticky bits.
//  Not defined: truncation (round toward zero); nx still reported; of saturates to inf identically.
// STRUCTURE
//  Package fp_mul_pkg: flag bit index constants (NV,OF,UF,NX), special-class enum
//    (ZERO,NORM,INF,NAN), canonical-NaN builder function.
//  Sub-module fp_mul_norm_round: S3 combinational normalise+round+pack (parametrised on EXP_W/MAN_W,
//    honours FP_MUL_ROUND_RNE_EN). Stages S1/S2 and handshake live in fp_mul_pipe.
// TESTING (EXP_W=5, MAN_W=10 unless noted)
//  1. 0x3C00*0x4000 (1.0*2.0) -> result 0x4000, flags 0, out_valid exactly 3 cycles after accept.
//  2. 0xC000*0x3800 (-2*0.5) -> 0xBC00; 0x3C01*0x3C01 -> 0x3C02, nx=1 (both rounding modes).
//  3. 0x7C00*0x0000 -> 0x7E00 nv=1; 0x7E00*0x3C00 -> 0x7E00 nv=1; 0xFC00*0x4000 -> 0xFC00 flags 0.
//  4. 0x7BFF*0x7BFF -> 0x7C00 of=1,nx=1; 0x0400*0x0400 -> 0x0000 uf=1,nx=1; subnormal 0x0001*0x3C00 -> 0x0000.
//  5. Back-to-back 16 ops, out_ready toggled pseudo-randomly -> results in order, none lost/duplicated,
//     result held stable while stalled; compare against reference model.
//  6. Assert rst_n low with 2 ops in flight -> out_valid=0 asynchronously, no stale results after release;
//     repeat case 1 with EXP_W=8, MAN_W=23: 0x3F800000*0x40000000 -> 0x40000000.

Source files
------------

// File: rtl/fp_mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fp_mul_pkg
//  Purpose  : Shared definitions for the pipelined floating-point multiplier.
//             Flag bit positions inside the {nv,of,uf,nx} flag vector, the
//             operand class enum and a canonical quiet-NaN builder.
//  Revision : 1.0  initial release
// ============================================================================
package fp_mul_pkg;

  // Bit positions inside the 4-bit flag vector {nv,of,uf,nx}
  localparam int C_FLAG_NV = 3;
  localparam int C_FLAG_OF = 2;
  localparam int C_FLAG_UF = 1;
  localparam int C_FLAG_NX = 0;

  // Operand classification; subnormals are folded into CLS_ZERO
  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fp_class_e;

  // Canonical qNaN {0, all-ones exponent, 100..0 mantissa}, right-aligned
  // in a 64-bit word; callers truncate to their own format width.
  function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
    logic [63:0] v;
    v = ((64'd1 << exp_w) - 64'd1) << man_w;
    v = v | (64'd1 << (man_w - 1));
    return v;
  endfunction

endpackage : fp_mul_pkg
`default_nettype wire

// File: rtl/fp_mul_norm_round.sv
`default_nettype none
// ============================================================================
//  Module   : fp_mul_norm_round
//  Purpose  : Final-stage combinational normalise, round and pack for the
//             pipelined multiplier. Selects the precomputed special result
//             when the operands were special, otherwise normalises the raw
//             significand product, rounds, and applies overflow/underflow.
//  Config   : FP_MUL_ROUND_RNE_EN defined -> round-to-nearest-even,
//             otherwise truncation (round toward zero).
//  Ports    : i_sign       result sign
//             i_exp        biased exponent sum, two's complement, EXP_W+2 bits
//             i_prod       (MAN_W+1)x(MAN_W+1) significand product
//             i_special    operands were special; use i_spec_res/i_spec_flags
//             i_spec_res   precomputed special result
//             i_spec_flags precomputed special flags
//             o_result     packed product
//             o_flags      {nv,of,uf,nx}
//  Revision : 1.0  initial release
// ============================================================================
module fp_mul_norm_round #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                   i_sign,
  input  logic [EXP_W+1:0]       i_exp,
  input  logic [2*MAN_W+1:0]     i_prod,
  input  logic                   i_special,
  input  logic [EXP_W+MAN_W:0]   i_spec_res,
  input  logic [3:0]             i_spec_flags,
  output logic [EXP_W+MAN_W:0]   o_result,
  output logic [3:0]             o_flags
);
  import fp_mul_pkg::*;

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam logic [EW-1:0] C_EXP_INF = EW'((2**EXP_W) - 1);

  logic             w_hi;
  logic [MAN_W-1:0] w_man_pre;
  logic [MAN_W:0]   w_disc;
  logic             w_rnd_up;
  logic [MAN_W:0]   w_man_sum;
  logic             w_carry;
  logic [MAN_W-1:0] w_man;
  logic [EW-1:0]    w_exp_n;
  logic             w_inexact;
  logic             w_ovf;
  logic             w_unf;

  // Product lies in [1,4): the top bit says whether it needs a 1-bit shift.
  assign w_hi      = i_prod[2*MAN_W+1];
  assign w_man_pre = w_hi ? i_prod[2*MAN_W:MAN_W+1] : i_prod[2*MAN_W-1:MAN_W];
  // Discarded bits, left-aligned so bit MAN_W is always the guard bit
  assign w_disc    = w_hi ? i_prod[MAN_W:0] : {i_prod[MAN_W-1:0], 1'b0};
  assign w_inexact = |w_disc;

`ifdef FP_MUL_ROUND_RNE_EN
  logic w_guard;
  logic w_sticky;
  assign w_guard  = w_disc[MAN_W];
  assign w_sticky = |w_disc[MAN_W-1:0];
  // Ties go to the even mantissa
  assign w_rnd_up = w_guard & (w_sticky | w_man_pre[0]);
`else
  assign w_rnd_up = 1'b0;
`endif

  // A carry out of the mantissa (1.11..1 -> 10.0) leaves the field at zero
  // and bumps the exponent.
  assign w_man_sum = {1'b0, w_man_pre} + (MAN_W+1)'(w_rnd_up);
  assign w_carry   = w_man_sum[MAN_W];
  assign w_man     = w_man_sum[MAN_W-1:0];
  assign w_exp_n   = i_exp + EW'(w_hi) + EW'(w_carry);

  // Exponent is two's complement: negative or zero means underflow.
  assign w_unf = w_exp_n[EW-1] | (w_exp_n == '0);
  assign w_ovf = !w_exp_n[EW-1] && (w_exp_n >= C_EXP_INF);

  always_comb begin
    o_result = '0;
    o_flags  = '0;
    if (i_special) begin
      o_result = i_spec_res;
      o_flags  = i_spec_flags;
    end else if (w_ovf) begin
      o_result           = {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      o_flags[C_FLAG_OF] = 1'b1;
      o_flags[C_FLAG_NX] = 1'b1;
    end else if (w_unf) begin
      o_result           = {i_sign, {(W-1){1'b0}}};
      o_flags[C_FLAG_UF] = 1'b1;
      o_flags[C_FLAG_NX] = 1'b1;
    end else begin
      o_result           = {i_sign, w_exp_n[EXP_W-1:0], w_man};
      o_flags[C_FLAG_NX] = w_inexact;
    end
  end

endmodule : fp_mul_norm_round
`default_nettype wire

// File: rtl/fp_mul_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : fp_mul_pipe
//  Purpose  : Three-stage pipelined floating-point multiplier with
//             valid/ready streaming and {nv,of,uf,nx} exception flags.
//             S1 unpack/classify/sign/exponent, S2 significand multiply,
//             S3 normalise/round/pack (fp_mul_norm_round) into the output
//             register. All stages advance together on a global enable.
//  Config   : FP_MUL_ROUND_RNE_EN selects round-to-nearest-even (default
//             build truncates).
//  Ports    : clk, rst_n (async active-low)
//             in_valid/in_ready, a, b     operand stream
//             out_valid/out_ready, result, flags  result stream
//  Revision : 1.0  initial release
// ============================================================================
module fp_mul_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic [3:0]           flags
);
  import fp_mul_pkg::*;

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * MAN_W + 2;
  localparam logic [EW-1:0] C_BIAS = EW'((2**(EXP_W-1)) - 1);
  localparam logic [W-1:0]  C_QNAN = W'(canon_nan(EXP_W, MAN_W));

  function automatic fp_class_e classify(input logic [EXP_W-1:0] e,
                                         input logic [MAN_W-1:0] m);
    if (e == '0)   return CLS_ZERO;
    else if (&e)   return (m == '0) ? CLS_INF : CLS_NAN;
    else           return CLS_NORM;
  endfunction

  // ---------------------------------------------------------------- handshake
  logic w_adv;
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  // ---------------------------------------------------------------- S1 comb
  fp_class_e      w_cls_a;
  fp_class_e      w_cls_b;
  logic           w_sign;
  logic [EW-1:0]  w_exp_sum;
  logic           w_special;
  logic [W-1:0]   w_spec_res;
  logic [3:0]     w_spec_flags;

  assign w_cls_a   = classify(a[W-2:MAN_W], a[MAN_W-1:0]);
  assign w_cls_b   = classify(b[W-2:MAN_W], b[MAN_W-1:0]);
  assign w_sign    = a[W-1] ^ b[W-1];
  assign w_exp_sum = EW'(a[W-2:MAN_W]) + EW'(b[W-2:MAN_W]) - C_BIAS;

  // Special cases in priority order: NaN / inf*0, then inf, then zero.
  always_comb begin
    w_special    = 1'b1;
    w_spec_res   = '0;
    w_spec_flags = '0;
    if (w_cls_a == CLS_NAN || w_cls_b == CLS_NAN ||
        (w_cls_a == CLS_INF  && w_cls_b == CLS_ZERO) ||
        (w_cls_a == CLS_ZERO && w_cls_b == CLS_INF)) begin
      w_spec_res              = C_QNAN;
      w_spec_flags[C_FLAG_NV] = 1'b1;
    end else if (w_cls_a == CLS_INF || w_cls_b == CLS_INF) begin
      w_spec_res = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_cls_a == CLS_ZERO || w_cls_b == CLS_ZERO) begin
      w_spec_res = {w_sign, {(W-1){1'b0}}};
    end else begin
      w_special = 1'b0;
    end
  end

  // ---------------------------------------------------------------- registers
  logic           r_s1_v;
  logic           r_s1_sign;
  logic [EW-1:0]  r_s1_exp;
  logic [MAN_W:0] r_s1_ma;
  logic [MAN_W:0] r_s1_mb;
  logic           r_s1_special;
  logic [W-1:0]   r_s1_spec_res;
  logic [3:0]     r_s1_spec_flags;

  logic           r_s2_v;
  logic           r_s2_sign;
  logic [EW-1:0]  r_s2_exp;
  logic [PW-1:0]  r_s2_prod;
  logic           r_s2_special;
  logic [W-1:0]   r_s2_spec_res;
  logic [3:0]     r_s2_spec_flags;

  logic           r_out_v;
  logic [W-1:0]   r_result;
  logic [3:0]     r_flags;

  logic [PW-1:0]  w_prod;
  logic [W-1:0]   w_nr_result;
  logic [3:0]     w_nr_flags;

  assign w_prod = PW'(r_s1_ma) * PW'(r_s1_mb);

  fp_mul_norm_round #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_norm_round (
    .i_sign       (r_s2_sign),
    .i_exp        (r_s2_exp),
    .i_prod       (r_s2_prod),
    .i_special    (r_s2_special),
    .i_spec_res   (r_s2_spec_res),
    .i_spec_flags (r_s2_spec_flags),
    .o_result     (w_nr_result),
    .o_flags      (w_nr_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v          <= 1'b0;
      r_s1_sign       <= 1'b0;
      r_s1_exp        <= '0;
      r_s1_ma         <= '0;
      r_s1_mb         <= '0;
      r_s1_special    <= 1'b0;
      r_s1_spec_res   <= '0;
      r_s1_spec_flags <= '0;
      r_s2_v          <= 1'b0;
      r_s2_sign       <= 1'b0;
      r_s2_exp        <= '0;
      r_s2_prod       <= '0;
      r_s2_special    <= 1'b0;
      r_s2_spec_res   <= '0;
      r_s2_spec_flags <= '0;
      r_out_v         <= 1'b0;
      r_result        <= '0;
      r_flags         <= '0;
    end else if (w_adv) begin
      // S1: hidden bit is always 1 here; zero/subnormal operands take the
      // special path so their significand never reaches the output.
      r_s1_v          <= in_valid;
      r_s1_sign       <= w_sign;
      r_s1_exp        <= w_exp_sum;
      r_s1_ma         <= {1'b1, a[MAN_W-1:0]};
      r_s1_mb         <= {1'b1, b[MAN_W-1:0]};
      r_s1_special    <= w_special;
      r_s1_spec_res   <= w_spec_res;
      r_s1_spec_flags <= w_spec_flags;
      // S2
      r_s2_v          <= r_s1_v;
      r_s2_sign       <= r_s1_sign;
      r_s2_exp        <= r_s1_exp;
      r_s2_prod       <= w_prod;
      r_s2_special    <= r_s1_special;
      r_s2_spec_res   <= r_s1_spec_res;
      r_s2_spec_flags <= r_s1_spec_flags;
      // S3 into the output register; bubbles leave the last result in place
      r_out_v         <= r_s2_v;
      if (r_s2_v) begin
        r_result <= w_nr_result;
        r_flags  <= w_nr_flags;
      end
    end
  end

  assign out_valid = r_out_v;
  assign result    = r_result;
  assign flags     = r_flags;

endmodule : fp_mul_pipe
`default_nettype wire
